usb3_skp_collapse: RTL

Parametrised receive-side SKP removal and word repacking stage for the USB 3.0 PHY receive path. It sits between the PIPE receive interface and the descrambler. It strips SKP K-symbols at any lane position and in any pattern, and repacks the surviving symbols into full NSYM-symbol words with a valid strobe. It also reports COM positions so the downstream LFSR can realign, keeps a SKP count, and offers a pass-through mode and a flush.

---
 rtl/usb3_pkg.sv | 16 +
 rtl/usb3_skp_collapse_if.sv | 24 ++
 rtl/usb3_sym_compact.sv | 78 +++++++
 rtl/usb3_skp_collapse.sv | 115 +++++++++++
 4 files changed

// File: rtl/usb3_pkg.sv
// rtl/usb3_pkg.sv - shared USB 3.0 receive-path constants and helpers
package usb3_pkg;

  localparam logic [7:0] K28_1_SKP = 8'h3C;
  localparam logic [7:0] K28_5_COM = 8'hBC;

  function automatic int clog2_sym(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/usb3_skp_collapse_if.sv
// rtl/usb3_skp_collapse_if.sv - receive symbol stream in and repacked word stream out
interface usb3_skp_collapse_if #(
  parameter int NSYM = 4
);

  logic                in_valid;
  logic [8*NSYM-1:0]   in_data;
  logic [NSYM-1:0]     in_datak;
  logic                out_valid;
  logic [8*NSYM-1:0]   out_data;
  logic [NSYM-1:0]     out_datak;
  logic [NSYM-1:0]     out_com;

  modport master (
    output in_valid, in_data, in_datak,
    input  out_valid, out_data, out_datak, out_com
  );

  modport slave (
    input  in_valid, in_data, in_datak,
    output out_valid, out_data, out_datak, out_com
  );

endinterface

// File: rtl/usb3_sym_compact.sv
// rtl/usb3_sym_compact.sv - stage 1: drop SKP symbols and pack survivors toward lane 0
module usb3_sym_compact
  import usb3_pkg::*;
#(
  parameter int         NSYM    = 4,
  parameter logic [7:0] SKP_SYM = K28_1_SKP
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         flush_i,
  input  logic                         enable_i,
  input  logic                         valid_i,
  input  logic [8*NSYM-1:0]            data_i,
  input  logic [NSYM-1:0]              datak_i,
  output logic [8*NSYM-1:0]            data_o,
  output logic [NSYM-1:0]              datak_o,
  output logic [clog2_sym(NSYM):0]     keep_o,
  output logic [clog2_sym(NSYM):0]     skp_o
);

  localparam int KW = clog2_sym(NSYM) + 1;

  logic [8*NSYM-1:0] data_d, data_q;
  logic [NSYM-1:0]   datak_d, datak_q;
  logic [KW-1:0]     keep_d, keep_q;
  logic [KW-1:0]     skp_d, skp_q;
  logic              is_skp;
  int                pos;
  int                skps;

  // pos is the output lane the next surviving symbol lands in
  always_comb begin
    data_d  = '0;
    datak_d = '0;
    is_skp  = 1'b0;
    pos     = 0;
    skps    = 0;
    for (int i = 0; i < NSYM; i++) begin
      is_skp = datak_i[i] && (data_i[8*i +: 8] == SKP_SYM);
      for (int j = 0; j < NSYM; j++) begin
        if (!is_skp && pos == j) begin
          data_d[8*j +: 8] = data_i[8*i +: 8];
          datak_d[j]       = datak_i[i];
        end
      end
      if (is_skp) skps = skps + 1;
      else        pos  = pos + 1;
    end
    if (!enable_i) begin
      data_d  = data_i;
      datak_d = datak_i;
      pos     = NSYM;
      skps    = 0;
    end
    keep_d = (valid_i && !flush_i) ? KW'(pos) : '0;
    skp_d  = valid_i ? KW'(skps) : '0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_q  <= '0;
      datak_q <= '0;
      keep_q  <= '0;
      skp_q   <= '0;
    end else begin
      data_q  <= data_d;
      datak_q <= datak_d;
      keep_q  <= keep_d;
      skp_q   <= skp_d;
    end
  end

  assign data_o  = data_q;
  assign datak_o = datak_q;
  assign keep_o  = keep_q;
  assign skp_o   = skp_q;

endmodule

// File: rtl/usb3_skp_collapse.sv
// rtl/usb3_skp_collapse.sv - SKP removal, word repacking, COM flags and SKP counting
module usb3_skp_collapse
  import usb3_pkg::*;
#(
  parameter int         NSYM    = 4,
  parameter logic [7:0] SKP_SYM = K28_1_SKP,
  parameter logic [7:0] COM_SYM = K28_5_COM
) (
  input  logic                local_clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                flush,
  usb3_skp_collapse_if.slave  sym_if,
  output logic [15:0]         skp_count
);

  localparam int KW = clog2_sym(NSYM) + 1;
  localparam int BN = 2 * NSYM;
  localparam int DW = clog2_sym(BN);

  logic [8*NSYM-1:0] c_data;
  logic [NSYM-1:0]   c_datak;
  logic [KW-1:0]     c_keep;
  logic [KW-1:0]     c_skp;

  logic [8*BN-1:0]   buf_d, buf_q;
  logic [BN-1:0]     bufk_d, bufk_q;
  logic [DW-1:0]     depth_d, depth_q;
  logic              pop;
  int                base;

  logic              out_valid_q;
  logic [8*NSYM-1:0] out_data_q;
  logic [NSYM-1:0]   out_datak_q;
  logic [NSYM-1:0]   out_com_d, out_com_q;
  logic [16:0]       skp_sum;
  logic [15:0]       skp_count_d, skp_count_q;

  usb3_sym_compact #(
    .NSYM    (NSYM),
    .SKP_SYM (SKP_SYM)
  ) u_compact (
    .clk_i    (local_clk),
    .reset_i  (reset),
    .flush_i  (flush),
    .enable_i (enable),
    .valid_i  (sym_if.in_valid),
    .data_i   (sym_if.in_data),
    .datak_i  (sym_if.in_datak),
    .data_o   (c_data),
    .datak_o  (c_datak),
    .keep_o   (c_keep),
    .skp_o    (c_skp)
  );

  // base is the occupancy left after this cycle's pop; new symbols append there
  always_comb begin
    pop    = (int'(depth_q) >= NSYM);
    base   = pop ? int'(depth_q) - NSYM : int'(depth_q);
    buf_d  = pop ? (buf_q >> (8*NSYM)) : buf_q;
    bufk_d = pop ? (bufk_q >> NSYM) : bufk_q;
    for (int s = 0; s < BN; s++) begin
      for (int i = 0; i < NSYM; i++) begin
        if (i < int'(c_keep) && s == base + i) begin
          buf_d[8*s +: 8] = c_data[8*i +: 8];
          bufk_d[s]       = c_datak[i];
        end
      end
    end
    depth_d = flush ? '0 : DW'(base + int'(c_keep));
  end

  always_comb begin
    out_com_d = '0;
    for (int j = 0; j < NSYM; j++) begin
      out_com_d[j] = bufk_q[j] && (buf_q[8*j +: 8] == COM_SYM);
    end
  end

  always_comb begin
    skp_sum     = {1'b0, skp_count_q} + 17'(c_skp);
    skp_count_d = skp_sum[16] ? 16'hFFFF : skp_sum[15:0];
  end

  always_ff @(posedge local_clk) begin
    if (reset) begin
      depth_q     <= '0;
      buf_q       <= '0;
      bufk_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_datak_q <= '0;
      out_com_q   <= '0;
      skp_count_q <= '0;
    end else begin
      depth_q     <= depth_d;
      buf_q       <= buf_d;
      bufk_q      <= bufk_d;
      out_valid_q <= pop && !flush;
      if (pop && !flush) begin
        out_data_q  <= buf_q[8*NSYM-1:0];
        out_datak_q <= bufk_q[NSYM-1:0];
        out_com_q   <= out_com_d;
      end
      skp_count_q <= skp_count_d;
    end
  end

  assign sym_if.out_valid = out_valid_q;
  assign sym_if.out_data  = out_data_q;
  assign sym_if.out_datak = out_datak_q;
  assign sym_if.out_com   = out_com_q;
  assign skp_count        = skp_count_q;

endmodule
